// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target engine.
//   spi_state_e     : engine state (idle / selected)
//   SPI_MODE0..3    : {cpol,cpha} encodings of the four SPI modes
//   SPI_SYNC_STAGES : depth of the pin synchronisers
//   sck_lead/trail  : classify a synced sck transition against CPOL
package spi_pkg;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_SYNC_STAGES = 2;

  // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
  function automatic logic sck_lead(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  function automatic logic sck_trail(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Host-side word interface of the SPI target.
//   tx_data_in/tx_valid_in/tx_ready_out : TX holding-register write handshake
//   rx_data_out/rx_valid_out            : received word plus one-cycle strobe
//   tx_underrun_out                     : word started with no TX data
// Modports: slave = the core, master = the register/FIFO side.
interface spi_slave_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data_in;
  logic                  tx_valid_in;
  logic                  tx_ready_out;
  logic [DATA_WIDTH-1:0] rx_data_out;
  logic                  rx_valid_out;
  logic                  tx_underrun_out;

  modport slave (
    input  tx_data_in, tx_valid_in,
    output tx_ready_out, rx_data_out, rx_valid_out, tx_underrun_out
  );

  modport master (
    output tx_data_in, tx_valid_in,
    input  tx_ready_out, rx_data_out, rx_valid_out, tx_underrun_out
  );
endinterface

// File: rtl/spi_slave_core_sync_edge.sv
// Pin synchroniser with registered edge pulses.
//   clk_in, rstn_in : system clock, async active-low reset
//   async_in        : asynchronous pin
//   rise_out        : one-cycle pulse on a synced 0->1 transition
//   fall_out        : one-cycle pulse on a synced 1->0 transition
// RST_VAL is the idle level of the pin so that reset release does not
// fabricate an edge.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rstn_in,
  input  logic async_in,
  output logic rise_out,
  output logic fall_out
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       hist_q;
  logic                       sync_s;

  assign sync_s = sync_q[SPI_SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      sync_q   <= {SPI_SYNC_STAGES{RST_VAL}};
      hist_q   <= RST_VAL;
      rise_out <= 1'b0;
      fall_out <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SPI_SYNC_STAGES-2:0], async_in};
      hist_q   <= sync_s;
      rise_out <= sync_s & ~hist_q;
      fall_out <= ~sync_s & hist_q;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples sck/ss_n/mosi in the clk_in domain,
// deserialises mosi into words and serialises a host word onto miso,
// in any of the four CPOL/CPHA modes.
//   clk_in, rstn_in     : system clock (>= 8x sck), async active-low reset
//   sck_in, ss_n_in     : SPI clock and select from the master (async)
//   mosi_in, miso_out   : serial data in / out
//   miso_oe_out         : miso driver enable, high while selected
//   cpol_in, cpha_in    : mode, latched at select
//   busy_out            : high while selected
//   host                : TX/RX word handshake (spi_slave_core_if.slave)
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic clk_in,
  input  logic rstn_in,
  input  logic sck_in,
  input  logic ss_n_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic miso_oe_out,
  input  logic cpol_in,
  input  logic cpha_in,
  output logic busy_out,
  spi_slave_core_if.slave host
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // ---------------- pin synchronisation ----------------
  logic sck_rise, sck_fall, ss_rise, ss_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk_in(clk_in), .rstn_in(rstn_in), .async_in(sck_in),
    .rise_out(sck_rise), .fall_out(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk_in(clk_in), .rstn_in(rstn_in), .async_in(ss_n_in),
    .rise_out(ss_rise), .fall_out(ss_fall)
  );

  // mosi gets the same depth as the sck edge pulse so the sampled bit is
  // the one present at the pin when sck moved.
  logic [SPI_SYNC_STAGES-1:0] mosi_sync_q;
  logic                       mosi_d;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      mosi_sync_q <= '0;
      mosi_d      <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SPI_SYNC_STAGES-2:0], mosi_in};
      mosi_d      <= mosi_sync_q[SPI_SYNC_STAGES-1];
    end
  end

  // ---------------- state ----------------
  spi_state_e            state_q, state_d;
  logic                  cpol_q, cpha_q;
  logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, hold_q, rx_shift_nxt;
  logic                  hold_vld_q, reload_pend_q;
  logic [CNT_W-1:0]      bit_cnt_q;

  logic active_edges, sample_evt, shift_evt, word_done;
  logic select_evt, load_evt, advance_evt, accept, tx_head;

  // Edges arriving with ss_n rising belong to a transfer that is ending.
  assign active_edges = (state_q == SPI_ACTIVE) && !ss_rise;
  assign sample_evt   = active_edges &&
                        (cpha_q ? sck_trail(cpol_q, sck_rise, sck_fall)
                                : sck_lead(cpol_q, sck_rise, sck_fall));
  assign shift_evt    = active_edges &&
                        (cpha_q ? sck_lead(cpol_q, sck_rise, sck_fall)
                                : sck_trail(cpol_q, sck_rise, sck_fall));
  assign word_done    = sample_evt && (bit_cnt_q == LAST_BIT);
  assign select_evt   = (state_q == SPI_IDLE) && ss_fall;

  // CPHA=0 needs the next head bit before the next leading edge, so it
  // reloads on completion; CPHA=1 defers to the following shift edge.
  assign load_evt     = select_evt || (word_done && !cpha_q) ||
                        (shift_evt && reload_pend_q);
  // A shift edge before any sample of the word (CPHA=1 first leading edge,
  // CPHA=0 trailing edge after completion) leaves the head bit alone.
  assign advance_evt  = shift_evt && !reload_pend_q && (bit_cnt_q != '0);

  assign host.tx_ready_out = !hold_vld_q || load_evt;
  assign accept            = host.tx_valid_in && host.tx_ready_out;

  assign rx_shift_nxt = (MSB_FIRST != 0) ? {rx_shift_q[DATA_WIDTH-2:0], mosi_d}
                                         : {mosi_d, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_head      = (MSB_FIRST != 0) ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state_q <= SPI_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_IDLE:   if (ss_fall) state_d = SPI_ACTIVE;
      SPI_ACTIVE: if (ss_rise) state_d = SPI_IDLE;
      default:    state_d = SPI_IDLE;
    endcase
  end

  always_comb begin
    busy_out    = 1'b0;
    miso_oe_out = 1'b0;
    miso_out    = 1'b0;
    if (state_q == SPI_ACTIVE) begin
      busy_out    = 1'b1;
      miso_oe_out = 1'b1;
      miso_out    = tx_head;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      cpol_q               <= 1'b0;
      cpha_q               <= 1'b0;
      tx_shift_q           <= '0;
      rx_shift_q           <= '0;
      hold_q               <= '0;
      hold_vld_q           <= 1'b0;
      reload_pend_q        <= 1'b0;
      bit_cnt_q            <= '0;
      host.rx_data_out     <= '0;
      host.rx_valid_out    <= 1'b0;
      host.tx_underrun_out <= 1'b0;
    end else begin
      if (select_evt) begin
        cpol_q <= cpol_in;
        cpha_q <= cpha_in;
      end

      if (load_evt)
        tx_shift_q <= hold_vld_q ? hold_q : '0;
      else if (advance_evt)
        tx_shift_q <= (MSB_FIRST != 0) ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};

      // Load drains the register first, so a same-cycle write refills it.
      if (accept) begin
        hold_q     <= host.tx_data_in;
        hold_vld_q <= 1'b1;
      end else if (load_evt) begin
        hold_vld_q <= 1'b0;
      end
      host.tx_underrun_out <= load_evt && !hold_vld_q;

      if (select_evt)                 reload_pend_q <= 1'b0;
      else if (word_done && cpha_q)   reload_pend_q <= 1'b1;
      else if (shift_evt)             reload_pend_q <= 1'b0;

      if (select_evt) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
      end else if (sample_evt) begin
        bit_cnt_q  <= word_done ? '0 : bit_cnt_q + 1'b1;
        rx_shift_q <= rx_shift_nxt;
      end

      host.rx_valid_out <= word_done;
      if (word_done) host.rx_data_out <= rx_shift_nxt;
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int HALF = 8;   // sck half period in clk cycles

  logic clk, rst_n, sck, ss_n, mosi, cpol, cpha;
  logic miso, miso_oe, busy;

  spi_slave_core_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_core #(.DATA_WIDTH(DW), .MSB_FIRST(1)) dut (
    .clk_in(clk), .rstn_in(rst_n), .sck_in(sck), .ss_n_in(ss_n),
    .mosi_in(mosi), .miso_out(miso), .miso_oe_out(miso_oe),
    .cpol_in(cpol), .cpha_in(cpha), .busy_out(busy), .host(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_samp_cyc = 0;
  int rx_pulses = 0;
  int un_pulses = 0;
  logic sel_ready;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] miso_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every received word must match the oldest pushed expectation
  // and arrive exactly 4 clk cycles after the final sample edge at the pin.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid_out) begin
      rx_pulses++;
      if (rx_q.size() == 0) chk("rx_unexpected", 32'(bus.rx_data_out), 32'hdead);
      else                  chk("rx_data", 32'(bus.rx_data_out), 32'(rx_q.pop_front()));
      chk("rx_latency", 32'(cyc - last_samp_cyc), 32'd4);
    end
    if (rst_n && bus.tx_underrun_out) un_pulses++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.tx_data_in  = d;
    bus.tx_valid_in = 1'b1;
    while (!bus.tx_ready_out && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept_timeout", 32'(n < 400), 32'd1);
    @(negedge clk);
    bus.tx_valid_in = 1'b0;
  endtask

  task automatic sel(input logic [1:0] mode);
    cpol = mode[1];
    cpha = mode[0];
    sck  = mode[1];
    wait_n(4);
    ss_n = 1'b0;
    wait_n(5);
    chk("sel_busy", 32'(busy), 32'd1);
    chk("sel_oe", 32'(miso_oe), 32'd1);
    sel_ready = bus.tx_ready_out;
  endtask

  task automatic desel();
    wait_n(HALF);
    ss_n = 1'b1;
    wait_n(6);
    chk("desel_oe", 32'(miso_oe), 32'd0);
    chk("desel_busy", 32'(busy), 32'd0);
    chk("desel_miso", 32'(miso), 32'd0);
  endtask

  // Master side of one word; returns the bits seen on miso, MSB first.
  task automatic spi_word(input logic cp, input logic ch, input logic [DW-1:0] mo,
                          input int nbits, output logic [DW-1:0] mi);
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!ch) mosi = mo[DW-1-b];
      wait_n(HALF);
      sck = ~cp;
      if (!ch) begin
        mi = {mi[DW-2:0], miso};
        last_samp_cyc = cyc;
      end else begin
        mosi = mo[DW-1-b];
      end
      wait_n(HALF);
      sck = cp;
      if (ch) begin
        mi = {mi[DW-2:0], miso};
        last_samp_cyc = cyc;
      end
    end
  endtask

  task automatic xfer(input logic [1:0] mode, input logic [15:0] mo, input int nw);
    logic [DW-1:0] mi;
    sel(mode);
    for (int w = 0; w < nw; w++) begin
      spi_word(mode[1], mode[0], mo[8*(nw-1-w) +: 8], DW, mi);
      if (miso_q.size() == 0) chk("miso_unexpected", 32'(mi), 32'hdead);
      else                    chk("miso_word", 32'(mi), 32'(miso_q.pop_front()));
    end
    desel();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int rx0, un0;
    logic [DW-1:0] mi;
    rst_n = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    bus.tx_data_in = '0; bus.tx_valid_in = 1'b0;
    wait_n(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_ready", 32'(bus.tx_ready_out), 32'd1);
    chk("rst_rx_data", 32'(bus.rx_data_out), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid_out), 32'd0);
    chk("rst_underrun", 32'(bus.tx_underrun_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_n(4);

    // Mode 0: host A5 out, master 3C in.
    tx_write(8'hA5);
    chk("t1_ready_full", 32'(bus.tx_ready_out), 32'd0);
    rx0 = rx_pulses;
    miso_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    xfer(SPI_MODE0, 16'h003C, 1);
    chk("t1_ready_after_sel", 32'(sel_ready), 32'd1);
    chk("t1_rx_pulses", 32'(rx_pulses - rx0), 32'd1);

    // Modes 1..3: 81 out, 7E in.
    for (int m = 1; m < 4; m++) begin
      tx_write(8'h81);
      rx0 = rx_pulses;
      miso_q.push_back(8'h81);
      rx_q.push_back(8'h7E);
      xfer(2'(m), 16'h007E, 1);
      chk("modes_rx_pulses", 32'(rx_pulses - rx0), 32'd1);
    end

    // Back-to-back words, second TX word written during word 1.
    tx_write(8'h11);
    rx0 = rx_pulses; un0 = un_pulses;
    miso_q.push_back(8'h11); miso_q.push_back(8'h22);
    rx_q.push_back(8'hA1);   rx_q.push_back(8'hB2);
    fork
      xfer(SPI_MODE1, 16'hA1B2, 2);
      begin
        wait_n(9 + 2*HALF*2 + 4);
        tx_write(8'h22);
      end
    join
    chk("b2b_rx_pulses", 32'(rx_pulses - rx0), 32'd2);
    chk("b2b_underrun", 32'(un_pulses - un0), 32'd0);

    // Select with empty holding register.
    un0 = un_pulses;
    miso_q.push_back(8'h00);
    rx_q.push_back(8'hC3);
    xfer(SPI_MODE1, 16'h00C3, 1);
    chk("underrun_pulses", 32'(un_pulses - un0), 32'd1);

    // Deselect after 5 bits: partial word is dropped.
    rx0 = rx_pulses;
    sel(SPI_MODE0);
    spi_word(1'b0, 1'b0, 8'hFF, 5, mi);
    desel();
    chk("abort_rx_pulses", 32'(rx_pulses - rx0), 32'd0);
    tx_write(8'h96);
    miso_q.push_back(8'h96);
    rx_q.push_back(8'h5A);
    xfer(SPI_MODE0, 16'h005A, 1);
    chk("after_abort_pulses", 32'(rx_pulses - rx0), 32'd1);

    // Reset mid-word with a full holding register.
    sel(SPI_MODE0);
    tx_write(8'h42);
    chk("mid_ready_full", 32'(bus.tx_ready_out), 32'd0);
    spi_word(1'b0, 1'b0, 8'hF0, 4, mi);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.tx_ready_out), 32'd1);
    chk("mid_rst_rx_data", 32'(bus.rx_data_out), 32'd0);
    ss_n = 1'b1;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(4);
    tx_write(8'h3C);
    rx0 = rx_pulses;
    miso_q.push_back(8'h3C);
    rx_q.push_back(8'h96);
    xfer(SPI_MODE0, 16'h0096, 1);
    chk("post_rst_pulses", 32'(rx_pulses - rx0), 32'd1);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI target (slave) engine: the far end of the SPI master link on miso/mosi/sck/ss.
- Oversamples the external SPI pins in the clk_in domain.
- Deserialises mosi into words and serialises a host-supplied word onto miso.
- Supports all four CPOL/CPHA modes.
- Presents a valid/ready byte interface to the internal register or FIFO side.

Parameters:
- DATA_WIDTH, 8: bits per SPI word (4..32).
- MSB_FIRST, 1: 1 = shift MSB first, 0 = LSB first.

Ports:
- clk_in  input  1  system clock; must be at least 8x the sck frequency.
- rstn_in  input  1  reset; asynchronous, active-low.
- sck_in  input  1  SPI clock from master (async).
- ss_n_in  input  1  slave select, active-low (async).
- mosi_in  input  1  master-out data (async).
- miso_out  output  1  slave-out data.
- miso_oe_out  output  1  miso tristate enable; high only while selected.
- cpol_in  input  1  clock polarity; latched at select.
- cpha_in  input  1  clock phase; latched at select.
- tx_data_in  input  DATA_WIDTH  next word to transmit.
- tx_valid_in  input  1  tx_data_in valid.
- tx_ready_out  output  1  TX holding register empty.
- rx_data_out  output  DATA_WIDTH  last received word.
- rx_valid_out  output  1  one-cycle pulse when rx_data_out updates.
- tx_underrun_out  output  1  one-cycle pulse when a word starts with no TX data.
- busy_out  output  1  high while selected (state ACTIVE).

Behaviour:
Reset values:
- miso_out=0, miso_oe_out=0, tx_ready_out=1, rx_data_out=0, rx_valid_out=0, tx_underrun_out=0, busy_out=0.
- Holding register, shift registers and bit counter all cleared.

Synchronisation and edge detection:
- sck, ss_n and mosi each pass through a 2-flop synchroniser, then one history flop for edge detection.
- Leading edge = synced sck leaving the CPOL level; trailing edge = returning to it.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.

State machine: IDLE, ACTIVE.
- IDLE -> ACTIVE on synced ss_n falling.
  - Latch cpol/cpha.
  - Load the TX shifter from the holding register if full, else load 0 and pulse tx_underrun_out.
  - Clear the bit counter; assert miso_oe_out and busy_out.
- ACTIVE -> IDLE on synced ss_n rising.
  - Discard any partial RX word; no rx_valid_out pulse.
  - Deassert miso_oe_out; miso_out goes to 0.
  - The holding register keeps its contents.

Bit timing:
- miso_out always drives the current head bit of the TX shifter. With CPHA=0 the first bit is therefore valid before the first sck edge.
- Sample edge: shift synced mosi into the RX shifter; increment the bit counter.
- Shift edge: advance the TX shifter. The shift edge that follows the final sample of a word does not shift; it reloads instead.
- Word complete (counter reaches DATA_WIDTH):
  - rx_data_out is loaded and rx_valid_out pulses 4 clk_in cycles after the final sample edge at the pin (2 sync + 1 edge + 1 output register).
  - The counter wraps to 0.
  - The TX shifter reloads from the holding register at the next shift edge. With CPHA=0 the reload instead occurs in the completion cycle. If the holding register is empty, load 0 and pulse underrun.

TX handshake:
- A write is accepted when tx_valid_in && tx_ready_out; tx_ready_out drops the next cycle.
- tx_ready_out rises in the cycle the shifter loads from the holding register.
- A write in the same cycle as a load is accepted after the load: the old word moves to the shifter and the new word fills the register.

Other boundary rules:
- An sck edge coincident with ss_n rising is ignored.
- sck activity while in IDLE is ignored.
- No RX overrun detection: the consumer must take rx_data_out before the next rx_valid_out.

Decomposition:
- Package spi_pkg:
  - state enum (SPI_IDLE, SPI_ACTIVE);
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - SPI_SYNC_STAGES=2.
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs; instantiated for sck and ss_n (mosi uses the synchroniser only).

Test Plan:
- Mode 0, host preloads 0xA5, master sends 0x3C: miso carries 1,0,1,0,0,1,0,1; rx_data_out=0x3C with one rx_valid_out pulse; tx_ready_out high after select.
- Modes 1, 2, 3 each exchange 0x81<->0x7E: correct data both ways; miso_oe_out high only while ss_n low.
- Back-to-back words with ss held low, TX 0x11 then 0x22 (second written mid-word 1): master receives 0x11, 0x22; two rx_valid_out pulses; no underrun.
- Select with empty holding register: tx_underrun_out pulses once; miso stays 0 for the whole word.
- ss_n rises after 5 bits: no rx_valid_out, busy_out falls; the next full transfer receives a correct 0x5A.
- rstn_in asserted mid-word: all outputs return to reset values immediately; the next transfer after release is correct.
